// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared FSM states, owner encoding and defaults for the SDRAM port arbiter
package sdram_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        OWN_WR  = 2'd0,
        OWN_RD0 = 2'd1,
        OWN_RD1 = 2'd2
    } owner_e;

    localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/sdram_port_arbiter_rr_pick2.sv
// rtl/sdram_port_arbiter_rr_pick2.sv - two-input round-robin chooser
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic prefer1,
    output logic gnt0,
    output logic gnt1
);

    // A lone requester always wins; the preference only breaks ties.
    assign gnt0 = req0 & (~req1 | ~prefer1);
    assign gnt1 = req1 & (~req0 |  prefer1);

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - one-outstanding-access arbiter for the byte-wide SDRAM port
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned AW      = 25,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter logic [7:0]  RD_FILL = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_ack,
    input  logic          rd0_req,
    input  logic [AW-1:0] rd0_addr,
    output logic [7:0]    rd0_data,
    output logic          rd0_valid,
    input  logic          rd1_req,
    input  logic [AW-1:0] rd1_addr,
    output logic [7:0]    rd1_data,
    output logic          rd1_valid,
    output logic [AW-1:0] sd_addr,
    output logic [7:0]    sd_din,
    output logic          sd_rd,
    output logic          sd_we,
    input  logic [7:0]    sd_dout,
    input  logic          sd_ready,
    output logic          timeout_err
);

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

    logic [1:0]  state;
    owner_e      owner;
    logic        prefer_rd1;
    logic        abandoned;
    logic [15:0] wd_cnt;
    logic [15:0] wd_next;
    logic        gnt_rd0;
    logic        gnt_rd1;

    rr_pick2 u_rr_pick2 (
        .req0    (rd0_req),
        .req1    (rd1_req),
        .prefer1 (prefer_rd1),
        .gnt0    (gnt_rd0),
        .gnt1    (gnt_rd1)
    );

    // wd_next counts the current WAIT cycle, so WAIT lasts at most TIMEOUT cycles.
    assign wd_next = wd_cnt + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_WR;
            prefer_rd1 <= 1'b0;
            abandoned  <= 1'b0;
            wd_cnt     <= 16'd0;
            sd_addr    <= '0;
            sd_din     <= 8'd0;
            rd0_data   <= 8'd0;
            rd1_data   <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_req) begin
                        owner   <= OWN_WR;
                        sd_addr <= wr_addr;
                        sd_din  <= wr_data;
                        state   <= ST_ISSUE;
                    end else if (gnt_rd0) begin
                        owner   <= OWN_RD0;
                        sd_addr <= rd0_addr;
                        state   <= ST_ISSUE;
                    end else if (gnt_rd1) begin
                        owner   <= OWN_RD1;
                        sd_addr <= rd1_addr;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_cnt    <= 16'd0;
                    abandoned <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    wd_cnt <= wd_next;
                    if (sd_ready) begin
                        if (owner == OWN_RD0) rd0_data <= sd_dout;
                        if (owner == OWN_RD1) rd1_data <= sd_dout;
                        state <= ST_DONE;
                    end else if (wd_next == WD_LIMIT) begin
                        if (owner == OWN_RD0) rd0_data <= RD_FILL;
                        if (owner == OWN_RD1) rd1_data <= RD_FILL;
                        abandoned <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (owner == OWN_RD0) prefer_rd1 <= 1'b1;
                    if (owner == OWN_RD1) prefer_rd1 <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes and pulses decode straight from state so reset clears them immediately.
    assign sd_we       = (state == ST_ISSUE) && (owner == OWN_WR);
    assign sd_rd       = (state == ST_ISSUE) && (owner != OWN_WR);
    assign wr_ack      = (state == ST_DONE)  && (owner == OWN_WR);
    assign rd0_valid   = (state == ST_DONE)  && (owner == OWN_RD0);
    assign rd1_valid   = (state == ST_DONE)  && (owner == OWN_RD1);
    assign timeout_err = (state == ST_DONE)  && abandoned;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    localparam int AW = 25;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req, rd0_req, rd1_req;
    logic [AW-1:0] wr_addr, rd0_addr, rd1_addr, sd_addr;
    logic [7:0]    wr_data, rd0_data, rd1_data, sd_din, sd_dout;
    logic          wr_ack, rd0_valid, rd1_valid, sd_rd, sd_we, sd_ready, timeout_err;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.AW(AW), .TIMEOUT(TO), .RD_FILL(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_valid(rd0_valid),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_rd(sd_rd), .sd_we(sd_we),
        .sd_dout(sd_dout), .sd_ready(sd_ready), .timeout_err(timeout_err)
    );

    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    logic [7:0]    mem [256];
    bit            rq_on [3];
    logic [AW-1:0] rq_addr [3];
    logic [7:0]    wr_dat;
    bit            auto_mode = 0;
    bit [2:0]      keep_mask = 3'b000;
    logic [2:0]    prev_req = 3'b000;
    bit            busy = 0;
    int            idle_from = 0;
    int            done_cyc = 0;
    int            own = 0;
    int            last_rd = 2;
    bit            exp_to = 0;
    logic [7:0]    exp_rd = 8'd0;
    logic [AW-1:0] cur_addr = '0;
    logic [7:0]    cur_wdat = 8'd0;
    logic [7:0]    last0 = 8'd0;
    logic [7:0]    last1 = 8'd0;
    int            rem = 0;
    logic [7:0]    ctl_dout = 8'd0;
    int            ctl_lat = 4;
    bit            ctl_rand = 0;
    bit            ctl_drop = 0;
    int            n_done = 0;
    int            last_issue = 0;
    int            last_done = 0;
    int            glog [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic new_req(input int i);
        rq_on[i]   = 1;
        rq_addr[i] = AW'($urandom);
        if (i == 0) wr_dat = 8'($urandom);
    endtask

    // One clock of bench activity at the falling edge: controller model, checks, requester drive.
    task automatic step();
        logic [1:0] obs_s, exp_s;
        logic [3:0] obs_p, exp_p;
        int lat;
        bit drop;
        @(negedge clk);
        cyc++;
        if (reset) begin
            busy = 0; idle_from = cyc + 1; last_rd = 2; last0 = 8'd0; last1 = 8'd0;
            for (int i = 0; i < 3; i++) rq_on[i] = 0;
        end
        sd_ready = 1'b0;
        sd_dout  = 8'($urandom);
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin sd_ready = 1'b1; sd_dout = ctl_dout; end
        end
        obs_s = {sd_we, sd_rd};
        exp_s = 2'b00;
        if (!busy && cyc >= idle_from + 1 && prev_req != 3'b000) begin
            if (prev_req[0]) own = 0;
            else if (prev_req[1] && prev_req[2]) own = (last_rd == 2) ? 1 : 2;
            else own = prev_req[1] ? 1 : 2;
            exp_s = (own == 0) ? 2'b10 : 2'b01;
        end
        if ((obs_s | exp_s) != 2'b00) check("strobe", 64'(obs_s), 64'(exp_s));
        if (exp_s != 2'b00) begin
            cur_addr = rq_addr[own];
            check("sd_addr", 64'(sd_addr), 64'(cur_addr));
            if (own == 0) begin cur_wdat = wr_dat; check("sd_din", 64'(sd_din), 64'(wr_dat)); end
            lat  = ctl_rand ? int'($urandom_range(1, TO + 4)) : ctl_lat;
            drop = ctl_rand ? ($urandom_range(0, 9) == 0) : ctl_drop;
            ctl_dout = mem[cur_addr[7:0]];
            rem      = drop ? 0 : lat;
            exp_to   = drop || (lat > TO);
            done_cyc = cyc + (exp_to ? TO : lat) + 1;
            exp_rd   = exp_to ? 8'hFF : ctl_dout;
            busy = 1; last_issue = cyc; glog.push_back(own);
        end
        obs_p = {timeout_err, rd1_valid, rd0_valid, wr_ack};
        exp_p = 4'b0000;
        if (busy && cyc == done_cyc) exp_p = {exp_to, own == 2, own == 1, own == 0};
        if ((obs_p | exp_p) != 4'b0000) check("done_pulse", 64'(obs_p), 64'(exp_p));
        if (exp_p != 4'b0000) begin
            if (own == 1) last0 = exp_rd;
            if (own == 2) last1 = exp_rd;
            if (own != 0) last_rd = own;
            else if (!exp_to) mem[cur_addr[7:0]] = cur_wdat;
            check("rd0_data", 64'(rd0_data), 64'(last0));
            check("rd1_data", 64'(rd1_data), 64'(last1));
            busy = 0; idle_from = cyc + 1; n_done++; last_done = cyc;
            if (keep_mask[own] || (auto_mode && $urandom_range(0, 1) == 1)) new_req(own);
            else rq_on[own] = 0;
        end
        if (auto_mode)
            for (int i = 0; i < 3; i++)
                if (!rq_on[i] && $urandom_range(0, (i == 0) ? 9 : 3) == 0) new_req(i);
        wr_req = rq_on[0]; wr_addr = rq_addr[0]; wr_data = wr_dat;
        rd0_req = rq_on[1]; rd0_addr = rq_addr[1];
        rd1_req = rq_on[2]; rd1_addr = rq_addr[2];
        prev_req = {rq_on[2], rq_on[1], rq_on[0]};
    endtask

    task automatic wait_idle(input int limit);
        bit idle;
        idle = 0;
        for (int k = 0; k < limit && !idle; k++) begin
            step();
            idle = !busy && !rq_on[0] && !rq_on[1] && !rq_on[2];
        end
        check("idle_reached", 64'(idle), 64'd1);
    endtask

    initial begin
        int nd0;
        reset = 1'b1;
        wr_req = 0; rd0_req = 0; rd1_req = 0;
        wr_addr = '0; rd0_addr = '0; rd1_addr = '0; wr_data = 8'd0;
        sd_dout = 8'd0; sd_ready = 1'b0; wr_dat = 8'd0;
        for (int i = 0; i < 3; i++) begin rq_on[i] = 0; rq_addr[i] = '0; end
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        repeat (3) step();
        check("reset_outputs", 64'({wr_ack, rd0_valid, rd1_valid, sd_rd, sd_we, timeout_err,
                                    sd_addr, sd_din, rd0_data, rd1_data}), 64'd0);
        reset = 1'b0;
        repeat (2) step();

        // single read from reader 0
        ctl_lat = 4; mem[8'h23] = 8'h5A;
        rq_addr[1] = 25'h0000123; rq_on[1] = 1;
        glog.delete();
        wait_idle(100);
        check("single_rd0_data", 64'(rd0_data), 64'h5A);
        check("single_latency", 64'(last_done - last_issue), 64'd5);

        // writer beats both readers
        wr_dat = 8'hC3; rq_addr[0] = AW'($urandom); rq_addr[1] = AW'($urandom); rq_addr[2] = AW'($urandom);
        rq_on[0] = 1; rq_on[1] = 1; rq_on[2] = 1;
        glog.delete();
        wait_idle(200);
        check("prio_first_writer", 64'(glog[0]), 64'd0);
        check("prio_sd_din", 64'(sd_din), 64'hC3);

        // readers held together alternate
        keep_mask = 3'b110; new_req(1); new_req(2);
        glog.delete(); nd0 = n_done;
        for (int k = 0; k < 200 && n_done < nd0 + 4; k++) step();
        keep_mask = 3'b000;
        wait_idle(200);
        check("rr_count", 64'(glog.size() >= 4), 64'd1);
        for (int k = 0; k < 3 && k + 1 < glog.size(); k++)
            check("rr_alternate", 64'(glog[k] + glog[k + 1]), 64'd3);

        // reader 1 timeout with a late ready afterwards
        ctl_lat = TO + 3; new_req(2);
        wait_idle(100);
        repeat (6) step();
        check("to_rd1_data", 64'(rd1_data), 64'hFF);
        check("to_latency", 64'(last_done - (last_issue - 1)), 64'd18);

        // ready on the very last WAIT cycle still succeeds
        ctl_lat = TO; rq_addr[1] = 25'h00000AB; mem[8'hAB] = 8'h3C; rq_on[1] = 1;
        wait_idle(100);
        check("bnd_rd0_data", 64'(rd0_data), 64'h3C);
        check("bnd_latency", 64'(last_done - last_issue), 64'(TO + 1));

        // reset in the middle of a reader 0 access
        ctl_lat = 6; new_req(1);
        for (int k = 0; k < 10 && !busy; k++) step();
        check("rst_issue", 64'(busy), 64'd1);
        nd0 = n_done;
        repeat (2) step();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("rst_async", 64'({wr_ack, rd0_valid, rd1_valid, sd_rd, sd_we, timeout_err,
                                   sd_addr, sd_din, rd0_data, rd1_data}), 64'd0);
        repeat (2) step();
        reset = 1'b0;
        step();
        ctl_lat = 3; new_req(2);
        wait_idle(100);
        check("rst_done_count", 64'(n_done - nd0), 64'd1);
        check("rst_last_owner", 64'(glog[glog.size() - 1]), 64'd2);

        // randomized traffic
        ctl_rand = 1; auto_mode = 1;
        repeat (3000) step();
        auto_mode = 0;
        wait_idle(2000);
        ctl_rand = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
